// File: rtl/pf_vf_rsp_merge.sv
// Merges per-function response streams onto one host-facing stream with
// packet-granular round-robin arbitration and per-port PF/VF header checking.
module pf_vf_rsp_merge #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 512,
  parameter int PF_W      = 3,
  parameter int VF_W      = 11,
  parameter int CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  input  logic [NUM_PORTS-1:0]            in_sop,
  input  logic [NUM_PORTS-1:0]            in_eop,
  input  logic [NUM_PORTS*DATA_W-1:0]     in_data,
  input  logic [NUM_PORTS*PF_W-1:0]       in_pf,
  input  logic [NUM_PORTS*VF_W-1:0]       in_vf,
  input  logic [NUM_PORTS-1:0]            in_vf_active,
  input  logic [NUM_PORTS*PF_W-1:0]       exp_pf,
  input  logic [NUM_PORTS*VF_W-1:0]       exp_vf,
  input  logic [NUM_PORTS-1:0]            exp_pf_any,
  input  logic [NUM_PORTS-1:0]            exp_vf_any,
  input  logic [NUM_PORTS-1:0]            exp_vf_active,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [DATA_W-1:0]               out_data,
  output logic [PF_W-1:0]                 out_pf,
  output logic [VF_W-1:0]                 out_vf,
  output logic                            out_vf_active,
  output logic [$clog2(NUM_PORTS)-1:0]    out_src_port,
  output logic [NUM_PORTS-1:0]            err_sticky,
  output logic [CNT_W-1:0]                drop_cnt
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [PTR_W-1:0]       gnt_q, gnt_d;
  logic [PF_W-1:0]        hdr_pf_q, hdr_pf_d;
  logic [VF_W-1:0]        hdr_vf_q, hdr_vf_d;
  logic                   hdr_vfa_q, hdr_vfa_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic [PF_W-1:0]        out_pf_q, out_pf_d;
  logic [VF_W-1:0]        out_vf_q, out_vf_d;
  logic                   out_vfa_q, out_vfa_d;
  logic [PTR_W-1:0]       out_src_q, out_src_d;
  logic [NUM_PORTS-1:0]   err_q, err_d;
  logic [CNT_W-1:0]       drop_q, drop_d;

  logic [NUM_PORTS-1:0]   cand;
  logic                   found, hi_found, lo_found;
  logic [PTR_W-1:0]       sel, hi_sel, lo_sel;
  logic [NUM_PORTS-1:0]   sel_oh;
  logic [PF_W-1:0]        c_pf, c_exp_pf;
  logic [VF_W-1:0]        c_vf, c_exp_vf;
  logic                   c_vfa, c_exp_vfa, c_pf_any, c_vf_any;
  logic                   match;

  logic [NUM_PORTS-1:0]   gnt_oh;
  logic                   g_valid, g_sop, g_eop;
  logic [DATA_W-1:0]      g_data;
  logic                   out_free;
  logic [NUM_PORTS-1:0]   rdy_vec;
  logic [PTR_W-1:0]       rr_after;

  // First SOP candidate at or above the pointer wins; otherwise wrap to the lowest.
  always_comb begin
    cand     = in_valid & in_sop;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (cand[p] && !lo_found) begin
        lo_found = 1'b1;
        lo_sel   = PTR_W'(p);
      end
      if (cand[p] && !hi_found && (p >= 32'(rr_q))) begin
        hi_found = 1'b1;
        hi_sel   = PTR_W'(p);
      end
    end
    found  = lo_found;
    sel    = hi_found ? hi_sel : lo_sel;
    sel_oh = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (PTR_W'(p) == sel) sel_oh[p] = found;
    end
  end

  always_comb begin
    c_pf      = '0;
    c_vf      = '0;
    c_vfa     = 1'b0;
    c_exp_pf  = '0;
    c_exp_vf  = '0;
    c_exp_vfa = 1'b0;
    c_pf_any  = 1'b0;
    c_vf_any  = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (sel_oh[p]) begin
        c_pf      = in_pf[p*PF_W +: PF_W];
        c_vf      = in_vf[p*VF_W +: VF_W];
        c_vfa     = in_vf_active[p];
        c_exp_pf  = exp_pf[p*PF_W +: PF_W];
        c_exp_vf  = exp_vf[p*VF_W +: VF_W];
        c_exp_vfa = exp_vf_active[p];
        c_pf_any  = exp_pf_any[p];
        c_vf_any  = exp_vf_any[p];
      end
    end
    match = (c_vfa == c_exp_vfa) &&
            (c_pf_any || (c_pf == c_exp_pf)) &&
            (c_vf_any || (c_vf == c_exp_vf));
  end

  always_comb begin
    gnt_oh = '0;
    g_data = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      gnt_oh[p] = (PTR_W'(p) == gnt_q);
      if (PTR_W'(p) == gnt_q) g_data = in_data[p*DATA_W +: DATA_W];
    end
    g_valid  = |(in_valid & gnt_oh);
    g_sop    = |(in_sop & gnt_oh);
    g_eop    = |(in_eop & gnt_oh);
    out_free = ~out_valid_q | out_ready;
    rr_after = (gnt_q == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_q + PTR_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    hdr_pf_d    = hdr_pf_q;
    hdr_vf_d    = hdr_vf_q;
    hdr_vfa_d   = hdr_vfa_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    out_pf_d    = out_pf_q;
    out_vf_d    = out_vf_q;
    out_vfa_d   = out_vfa_q;
    out_src_d   = out_src_q;
    err_d       = err_q;
    drop_d      = drop_q;
    rdy_vec     = '0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d     = sel;
          hdr_pf_d  = c_pf;
          hdr_vf_d  = c_vf;
          hdr_vfa_d = c_vfa;
          if (match) begin
            state_d = FWD;
          end else begin
            state_d = DROP;
            err_d   = err_q | sel_oh;
            if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
          end
        end
      end
      FWD: begin
        rdy_vec = gnt_oh & {NUM_PORTS{out_free}};
        // Header/source reach the output only with a beat, so a stalled EOP
        // of the previous packet keeps its own header until it drains.
        if (g_valid && out_free) begin
          out_valid_d = 1'b1;
          out_sop_d   = g_sop;
          out_eop_d   = g_eop;
          out_data_d  = g_data;
          out_pf_d    = hdr_pf_q;
          out_vf_d    = hdr_vf_q;
          out_vfa_d   = hdr_vfa_q;
          out_src_d   = gnt_q;
          if (g_eop) begin
            state_d = IDLE;
            rr_d    = rr_after;
          end
        end
      end
      DROP: begin
        rdy_vec = gnt_oh;
        if (g_valid && g_eop) begin
          state_d = IDLE;
          rr_d    = rr_after;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      hdr_pf_q    <= '0;
      hdr_vf_q    <= '0;
      hdr_vfa_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
      out_pf_q    <= '0;
      out_vf_q    <= '0;
      out_vfa_q   <= 1'b0;
      out_src_q   <= '0;
      err_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      hdr_pf_q    <= hdr_pf_d;
      hdr_vf_q    <= hdr_vf_d;
      hdr_vfa_q   <= hdr_vfa_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
      out_pf_q    <= out_pf_d;
      out_vf_q    <= out_vf_d;
      out_vfa_q   <= out_vfa_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
    end
  end

  assign in_ready      = rdy_vec & {NUM_PORTS{~rst}};
  assign out_valid     = out_valid_q;
  assign out_sop       = out_sop_q;
  assign out_eop       = out_eop_q;
  assign out_data      = out_data_q;
  assign out_pf        = out_pf_q;
  assign out_vf        = out_vf_q;
  assign out_vf_active = out_vfa_q;
  assign out_src_port  = out_src_q;
  assign err_sticky    = err_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_pf_vf_rsp_merge.sv
// Directed bench for pf_vf_rsp_merge: per-port beat sources, output capture,
// and immediate-assertion checks against hand-computed expectations.
module tb_pf_vf_rsp_merge;

  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int PW    = 3;
  localparam int VW    = 11;
  localparam int CW    = 2;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [PW-1:0] pf;
    logic [VW-1:0] vf;
    logic          vfa;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [PW-1:0] pf;
    logic [VW-1:0] vf;
    logic          vfa;
    logic [1:0]    src;
  } obeat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     in_valid, in_ready, in_sop, in_eop, in_vf_active;
  logic [NP*DW-1:0]  in_data;
  logic [NP*PW-1:0]  in_pf, exp_pf;
  logic [NP*VW-1:0]  in_vf, exp_vf;
  logic [NP-1:0]     exp_pf_any, exp_vf_any, exp_vf_active, err_sticky;
  logic              out_valid, out_ready, out_sop, out_eop, out_vf_active;
  logic [DW-1:0]     out_data;
  logic [PW-1:0]     out_pf;
  logic [VW-1:0]     out_vf;
  logic [1:0]        out_src_port;
  logic [CW-1:0]     drop_cnt;

  pf_vf_rsp_merge #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .PF_W      (PW),
    .VF_W      (VW),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_data       (in_data),
    .in_pf         (in_pf),
    .in_vf         (in_vf),
    .in_vf_active  (in_vf_active),
    .exp_pf        (exp_pf),
    .exp_vf        (exp_vf),
    .exp_pf_any    (exp_pf_any),
    .exp_vf_any    (exp_vf_any),
    .exp_vf_active (exp_vf_active),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .out_data      (out_data),
    .out_pf        (out_pf),
    .out_vf        (out_vf),
    .out_vf_active (out_vf_active),
    .out_src_port  (out_src_port),
    .err_sticky    (err_sticky),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int     n_assert = 0;
  int     n_fail   = 0;
  beat_t  src_mem [NP][DEPTH];
  int     head [NP];
  int     tail [NP];
  obeat_t out_q [$];

  logic [NP-1:0] s_in_ready, s_err;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [CW-1:0] s_drop;
  logic [1:0]    s_out_src;
  logic [PW-1:0] s_out_pf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] edata(input int port, input int tag, input int b);
    return {8'(port), 8'(tag), 16'(b)};
  endfunction

  function automatic obeat_t exp_beat(input int port, input int tag, input int b, input int n,
                                      input int pf, input int vf, input logic vfa);
    obeat_t e;
    e.data = edata(port, tag, b);
    e.sop  = (b == 0);
    e.eop  = (b == n - 1);
    e.pf   = PW'(pf);
    e.vf   = VW'(vf);
    e.vfa  = vfa;
    e.src  = 2'(port);
    return e;
  endfunction

  // Non-SOP beats carry inverted header fields so a DUT that resamples them shows up.
  task automatic add_pkt(input int port, input int n, input int pf, input int vf,
                         input logic vfa, input int tag);
    beat_t x;
    for (int b = 0; b < n; b++) begin
      x.data = edata(port, tag, b);
      x.sop  = (b == 0);
      x.eop  = (b == n - 1);
      x.pf   = (b == 0) ? PW'(pf) : ~PW'(pf);
      x.vf   = (b == 0) ? VW'(vf) : ~VW'(vf);
      x.vfa  = (b == 0) ? vfa : ~vfa;
      src_mem[port][tail[port]] = x;
      tail[port] = (tail[port] + 1) % DEPTH;
    end
  endtask

  task automatic drive();
    beat_t x;
    for (int p = 0; p < NP; p++) begin
      if (head[p] != tail[p]) x = src_mem[p][head[p]];
      else                    x = '0;
      in_valid[p]           = (head[p] != tail[p]);
      in_sop[p]             = x.sop;
      in_eop[p]             = x.eop;
      in_data[p*DW +: DW]   = x.data;
      in_pf[p*PW +: PW]     = x.pf;
      in_vf[p*VW +: VW]     = x.vf;
      in_vf_active[p]       = x.vfa;
    end
  endtask

  task automatic tick();
    logic [NP-1:0] acc;
    obeat_t        ob;
    drive();
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_err       = err_sticky;
    s_drop      = drop_cnt;
    s_out_src   = out_src_port;
    s_out_pf    = out_pf;
    acc         = in_valid & in_ready;
    if (out_valid && out_ready) begin
      ob = '{data: out_data, sop: out_sop, eop: out_eop, pf: out_pf,
             vf: out_vf, vfa: out_vf_active, src: out_src_port};
      out_q.push_back(ob);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) if (acc[p]) head[p] = (head[p] + 1) % DEPTH;
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) head[p] = tail[p];
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    out_q.delete();
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int c = 0;
    while (out_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, out_q.size(), n);
  endtask

  task automatic check_pkt(input int idx0, input int port, input int tag, input int n,
                           input int pf, input int vf, input logic vfa, input string name);
    for (int b = 0; b < n; b++) begin
      if (idx0 + b < out_q.size())
        chk(name, out_q[idx0 + b], exp_beat(port, tag, b, n, pf, vf, vfa));
      else
        chk({name, "_missing"}, out_q.size(), idx0 + b + 1);
    end
  endtask

  initial begin
    int   c, n_rdy;
    logic ov_seen, pv, pr, eop_seen;
    logic [DW-1:0] pd;

    rst = 1'b1; out_ready = 1'b1;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
    in_pf = '0; in_vf = '0; in_vf_active = '0;
    exp_pf = '0; exp_vf = '0; exp_pf_any = '1; exp_vf_any = '1; exp_vf_active = '0;
    for (int p = 0; p < NP; p++) begin head[p] = 0; tail[p] = 0; end

    do_reset();
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_in_ready", s_in_ready, 0);
    chk("rst_err", s_err, 0);
    chk("rst_drop", s_drop, 0);
    chk("rst_out_data", s_out_data, 0);
    chk("rst_out_src", s_out_src, 0);
    chk("rst_out_pf", s_out_pf, 0);

    // Single 4-beat packet on port 2 with PF match and VF wildcard
    exp_pf[2*PW +: PW] = 3'd1;
    exp_pf_any[2]      = 1'b0;
    add_pkt(2, 4, 1, 7, 1'b0, 'h11);
    tick();
    chk("t1_idle_rdy", s_in_ready, 0);
    chk("t1_idle_ov", s_out_valid, 0);
    tick();
    chk("t1_gnt_rdy", s_in_ready, 4'b0100);
    chk("t1_gnt_ov", s_out_valid, 0);
    tick();
    chk("t1_first_ov", s_out_valid, 1);
    run_until(4, 20, "t1_cnt");
    check_pkt(0, 2, 'h11, 4, 1, 7, 1'b0, "t1_beat");
    chk("t1_err", s_err, 0);
    chk("t1_drop", s_drop, 0);
    out_q.delete();

    // Round-robin order, packet atomicity, wrap-around of the pointer
    do_reset();
    add_pkt(0, 2, 0, 16, 1'b0, 'h20);
    add_pkt(1, 2, 0, 17, 1'b0, 'h21);
    add_pkt(3, 2, 0, 19, 1'b0, 'h23);
    run_until(6, 40, "t2a_cnt");
    check_pkt(0, 0, 'h20, 2, 0, 16, 1'b0, "t2a_p0");
    check_pkt(2, 1, 'h21, 2, 0, 17, 1'b0, "t2a_p1");
    check_pkt(4, 3, 'h23, 2, 0, 19, 1'b0, "t2a_p3");
    out_q.delete();
    tick();
    add_pkt(0, 2, 0, 32, 1'b0, 'h30);
    add_pkt(3, 2, 0, 35, 1'b0, 'h33);
    run_until(4, 30, "t2b_cnt");
    check_pkt(0, 0, 'h30, 2, 0, 32, 1'b0, "t2b_p0");
    check_pkt(2, 3, 'h33, 2, 0, 35, 1'b0, "t2b_p3");
    out_q.delete();
    tick();
    add_pkt(1, 1, 0, 40, 1'b0, 'h41);
    run_until(1, 10, "t2c_cnt1");
    check_pkt(0, 1, 'h41, 1, 0, 40, 1'b0, "t2c_p1");
    out_q.delete();
    tick();
    add_pkt(0, 1, 0, 50, 1'b0, 'h50);
    add_pkt(3, 1, 0, 53, 1'b0, 'h53);
    run_until(2, 20, "t2c_cnt2");
    check_pkt(0, 3, 'h53, 1, 0, 53, 1'b0, "t2c_p3_first");
    check_pkt(1, 0, 'h50, 1, 0, 50, 1'b0, "t2c_p0_second");
    out_q.delete();

    // PF mismatch on port 1: dropped while out_ready is low
    exp_pf[1*PW +: PW] = 3'd2;
    exp_pf_any[1]      = 1'b0;
    out_ready          = 1'b0;
    add_pkt(1, 3, 5, 9, 1'b0, 'h60);
    tick();
    n_rdy = 0;
    ov_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (s_in_ready == 4'b0010) n_rdy++;
      ov_seen = ov_seen | s_out_valid;
    end
    chk("t3_rdy_cycles", n_rdy, 3);
    chk("t3_no_out", ov_seen, 0);
    chk("t3_err", s_err, 4'b0010);
    chk("t3_drop", s_drop, 1);
    chk("t3_consumed", head[1], tail[1]);
    out_ready     = 1'b1;
    exp_pf_any[1] = 1'b1;

    // 8-beat packet under out_ready pattern 1,0,0,1
    add_pkt(0, 8, 3, 70, 1'b0, 'h70);
    c = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    while (out_q.size() < 8 && c < 80) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick();
      if (pv && !pr) begin
        chk("t4_hold_valid", s_out_valid, 1);
        chk("t4_hold_data", s_out_data, pd);
      end
      pv = s_out_valid;
      pr = out_ready;
      pd = s_out_data;
      c++;
    end
    chk("t4_cnt", out_q.size(), 8);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t4_nodup", out_q.size(), 8);
    check_pkt(0, 0, 'h70, 8, 3, 70, 1'b0, "t4_beat");
    out_q.delete();

    // Drop counter saturation with vf_active and VF mismatches on port 3
    do_reset();
    chk("t5_rst_drop", s_drop, 0);
    chk("t5_rst_err", s_err, 0);
    exp_vf_active[3]   = 1'b1;
    exp_vf[3*VW +: VW] = 11'd5;
    exp_vf_any[3]      = 1'b0;
    for (int k = 0; k < 5; k++) begin
      add_pkt(3, 1, k, ((k % 2) == 0) ? 5 : 6, ((k % 2) == 1), 'h80 + k);
      c = 0;
      while (head[3] != tail[3] && c < 10) begin
        tick();
        c++;
      end
      chk("t5_consumed", head[3], tail[3]);
      tick();
      chk("t5_drop", s_drop, (k + 1 > 3) ? 3 : k + 1);
    end
    chk("t5_err", s_err, 4'b1000);
    chk("t5_no_out", out_q.size(), 0);
    add_pkt(3, 1, 2, 5, 1'b1, 'h90);
    run_until(1, 10, "t5_match_cnt");
    check_pkt(0, 3, 'h90, 1, 2, 5, 1'b1, "t5_match");
    chk("t5_drop_held", s_drop, 3);
    out_q.delete();

    // Reset in the middle of a forwarded packet
    add_pkt(1, 1, 0, 1, 1'b0, 'hA1);
    run_until(1, 10, "t6_pre_cnt");
    out_q.delete();
    tick();
    add_pkt(2, 6, 1, 3, 1'b0, 'hB2);
    tick(); tick(); tick(); tick();
    chk("t6_mid_ov", s_out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_ov", s_out_valid, 0);
    chk("t6_rdy", s_in_ready, 0);
    chk("t6_err", s_err, 0);
    chk("t6_drop", s_drop, 0);
    chk("t6_data", s_out_data, 0);
    chk("t6_src", s_out_src, 0);
    tick();
    chk("t6_nosop_rdy", s_in_ready, 0);
    chk("t6_nosop_ov", s_out_valid, 0);
    eop_seen = 1'b0;
    foreach (out_q[i]) eop_seen = eop_seen | out_q[i].eop;
    chk("t6_no_eop", eop_seen, 0);
    for (int p = 0; p < NP; p++) head[p] = tail[p];
    out_q.delete();
    add_pkt(3, 1, 0, 5, 1'b1, 'hC3);
    add_pkt(1, 1, 0, 2, 1'b0, 'hC1);
    run_until(2, 20, "t6_rr_cnt");
    check_pkt(0, 1, 'hC1, 1, 0, 2, 1'b0, "t6_rr_p1");
    check_pkt(1, 3, 'hC3, 1, 0, 5, 1'b1, "t6_rr_p3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
